// File: rtl/mem_arbiter.sv
// Shares one main-memory port between I-cache fills, D-cache fills and D-side write-through stores.
// Fills issue WORDS_PER_BLK pipelined reads and stream the returned words into the requesting cache.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_BLK) + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'(2 * WORDS_PER_BLK - 1));
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

  // State register: the block base address is data and is not reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
    base_q <= base_d;
  end

  // Next state: priority is only evaluated in IDLE, fills always run to completion
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss_req) begin
          state_d = FILL_D;
          base_d  = d_miss_addr & BLK_MASK;
        end else if (i_miss_req) begin
          state_d = FILL_I;
          base_d  = i_miss_addr & BLK_MASK;
        end
      end
      WRITE: state_d = IDLE;
      FILL_I, FILL_D: begin
        if (issue_cnt_q != CNT_FULL) issue_cnt_d = issue_cnt_q + 1'b1;
        if (mem_valid) begin
          if (recv_cnt_q == CNT_LAST) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
          end else begin
            recv_cnt_d = recv_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: memory port and fill stream decoded from registered state
  always_comb begin
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_addr   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
      end
      FILL_I, FILL_D: begin
        if (issue_cnt_q != CNT_FULL) begin
          mem_en   = 1'b1;
          mem_addr = word_addr(base_q, issue_cnt_q);
        end
        if (mem_valid) begin
          fill_data = mem_rdata;
          fill_addr = word_addr(base_q, recv_cnt_q);
          if (state_q == FILL_I) begin
            i_fill_we   = 1'b1;
            i_fill_done = (recv_cnt_q == CNT_LAST);
          end else begin
            d_fill_we   = 1'b1;
            d_fill_done = (recv_cnt_q == CNT_LAST);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory model plus a scoreboard of expected
// memory accesses and cache fill words, driven by a vector table and corner-case sequences.
module tb_mem_arbiter;

  localparam int L   = 4;
  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data, fill_addr;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

  logic [L-1:0] pv = '0;
  logic [15:0]  pd [L];
  logic         force_valid = 1'b0;
  logic [15:0]  force_data  = 16'h0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic wr; logic [15:0] addr; logic [15:0] data;} acc_t;
  typedef struct packed {logic is_d; logic [15:0] addr; logic [15:0] data; logic last;} fill_t;
  typedef struct {logic is_d; logic [15:0] addr; logic [15:0] base; int first_off; int done_off;} vec_t;

  acc_t  acc_q[$];
  fill_t fill_q[$];
  vec_t  vecs[5];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(WPB)) dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_addr(fill_addr),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Memory model: a read sampled at edge t returns data valid L edges later
  always_ff @(posedge clk) begin
    pv    <= {pv[L-2:0], mem_en & ~mem_wr};
    pd[0] <= mem_word(mem_addr);
    for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
  end
  assign mem_valid = pv[L-1] | force_valid;
  assign mem_rdata = force_valid ? force_data : pd[L-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_fill(input logic is_d, input logic [15:0] base);
    for (int k = 0; k < WPB; k++) begin
      logic [15:0] a;
      a = base + 16'(2 * k);
      acc_q.push_back('{wr: 1'b0, addr: a, data: 16'h0});
      fill_q.push_back('{is_d: is_d, addr: a, data: mem_word(a), last: (k == WPB - 1)});
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT presents there
  task automatic tick();
    acc_t  a;
    fill_t f;
    @(negedge clk);
    if (mem_en === 1'b1) begin
      if (acc_q.size() == 0) flag("unexpected_access");
      else begin
        a = acc_q.pop_front();
        check("mem_wr", mem_wr, a.wr);
        check("mem_addr", mem_addr, a.addr);
        if (a.wr) check("mem_wdata", mem_wdata, a.data);
      end
    end
    if (i_fill_we | d_fill_we) begin
      if (fill_q.size() == 0) flag("unexpected_fill");
      else begin
        f = fill_q.pop_front();
        check("fill_side", {i_fill_we, d_fill_we}, f.is_d ? 2'b01 : 2'b10);
        check("fill_addr", fill_addr, f.addr);
        check("fill_data", fill_data, f.data);
        check("fill_done", {i_fill_done, d_fill_done}, f.last ? (f.is_d ? 2'b01 : 2'b10) : 2'b00);
      end
    end else if (i_fill_done | d_fill_done) begin
      flag("done_without_we");
    end
  endtask

  task automatic run_fill(input logic is_d, input logic [15:0] addr, input logic [15:0] base,
                          input int drop_at, output int first_off, output int done_off);
    push_fill(is_d, base);
    first_off = -1;
    done_off  = -1;
    if (is_d) begin d_miss_addr = addr; d_miss_req = 1'b1; end
    else      begin i_miss_addr = addr; i_miss_req = 1'b1; end
    for (int n = 0; n < 40 && done_off < 0; n++) begin
      tick();
      if (first_off < 0 && (i_fill_we | d_fill_we)) first_off = n;
      if (n == drop_at) begin i_miss_req = 1'b0; d_miss_req = 1'b0; end
      if (is_d ? d_fill_done : i_fill_done) begin
        done_off = n;
        i_miss_req = 1'b0;
        d_miss_req = 1'b0;
      end
    end
    if (done_off < 0) flag("fill_timeout");
    tick();
    check("busy_after_done", busy, 1'b0);
    check("queues_drained", acc_q.size() + fill_q.size(), 0);
  endtask

  initial begin
    int first_off, done_off, ack_cnt, d_stamp, i_stamp;

    vecs[0] = '{1'b1, 16'h1236, 16'h1230, L, WPB + L - 1};
    vecs[1] = '{1'b0, 16'hFFF8, 16'hFFF0, L, WPB + L - 1};
    vecs[2] = '{1'b0, 16'h000F, 16'h0000, L, WPB + L - 1};
    vecs[3] = '{1'b1, 16'hABCD, 16'hABC0, L, WPB + L - 1};
    vecs[4] = '{1'b0, 16'h7FF1, 16'h7FF0, L, WPB + L - 1};

    rst = 1'b1;
    i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (6) tick();
    check("reset_outputs",
          {busy, mem_en, mem_wr, d_wr_ack, i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 8'h00);
    check("reset_buses", {mem_addr, fill_addr}, 32'h0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_fill(vecs[i].is_d, vecs[i].addr, vecs[i].base, -1, first_off, done_off);
      check("first_fill_offset", first_off, vecs[i].first_off);
      check("done_offset", done_off, vecs[i].done_off);
    end

    // Store, D miss and I miss raised together
    acc_q.push_back('{wr: 1'b1, addr: 16'h0040, data: 16'hBEEF});
    push_fill(1'b1, 16'h3450);
    push_fill(1'b0, 16'h5670);
    d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    d_miss_addr = 16'h3456; d_miss_req = 1'b1;
    i_miss_addr = 16'h567A; i_miss_req = 1'b1;
    ack_cnt = 0; d_stamp = -1; i_stamp = -1;
    for (int n = 0; n < 100 && i_stamp < 0; n++) begin
      tick();
      if (d_wr_ack) begin ack_cnt++; d_wr_req = 1'b0; end
      if (d_fill_done) begin d_stamp = n; d_miss_req = 1'b0; end
      if (i_fill_done) begin i_stamp = n; i_miss_req = 1'b0; end
    end
    check("wr_ack_pulses", ack_cnt, 1);
    check("d_done_seen", d_stamp >= 0, 1'b1);
    check("i_after_d", i_stamp > d_stamp, 1'b1);
    tick();
    check("prio_queues_drained", acc_q.size() + fill_q.size(), 0);

    // Reset in the middle of a fill: stray returns afterwards must be dropped
    push_fill(1'b0, 16'h2000);
    i_miss_addr = 16'h2004; i_miss_req = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1; i_miss_req = 1'b0;
    acc_q.delete(); fill_q.delete();
    tick();
    check("rst_midfill_outputs", {busy, mem_en, i_fill_we, d_fill_we, i_fill_done}, 5'b0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    check("no_stray_fill", fill_q.size(), 0);
    run_fill(1'b0, 16'h2004, 16'h2000, -1, first_off, done_off);
    check("after_rst_done_offset", done_off, WPB + L - 1);

    // A mem_valid pulse while idle is ignored
    force_data = 16'hDEAD; force_valid = 1'b1;
    #1;
    check("idle_valid_ignored", {i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy}, 5'b0);
    tick();
    force_valid = 1'b0;
    tick();

    // Request dropped mid-fill still completes the block
    run_fill(1'b0, 16'h0102, 16'h0100, 2, first_off, done_off);
    check("dropped_req_done_offset", done_off, WPB + L - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
